// File: rtl/ex_mem_skid_if.sv
// Execute-to-LSU beat interface for ex_mem_skid: input handshake and payload, output beat and occupancy.
interface ex_mem_skid_if #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INS_W  = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [PC_W-1:0]   pc_i;
  logic [INS_W-1:0]  ins_i;
  logic [DATA_W-1:0] data_i;
  logic              branch_tag_i;
  logic              branch_slot_end_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [PC_W-1:0]   pc_o;
  logic [INS_W-1:0]  ins_o;
  logic [DATA_W-1:0] data_o;
  logic [1:0]        occupancy_o;

  modport slave (
    input  in_valid_i, pc_i, ins_i, data_i, branch_tag_i, branch_slot_end_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, ins_o, data_o, occupancy_o
  );

  modport master (
    output in_valid_i, pc_i, ins_i, data_i, branch_tag_i, branch_slot_end_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, ins_o, data_o, occupancy_o
  );
endinterface

// File: rtl/ex_mem_skid.sv
// EX/MEM stage as a 2-entry skid buffer with branch-shadow PC attribution.
// Optional PIPE_STATS_EN adds saturating stall and flush-drop counters.
module ex_mem_skid #(
  parameter int unsigned      DATA_W  = 160,
  parameter int unsigned      PC_W    = 32,
  parameter int unsigned      INS_W   = 32,
  parameter logic [INS_W-1:0] NOP_INS = INS_W'(32'h00000013)
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             flush_i,
  ex_mem_skid_if.slave     bus
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      drop_cnt_o
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INS_W-1:0]  ins;
    logic [DATA_W-1:0] data;
  } beat_t;

  localparam beat_t BUBBLE = '{pc: '0, ins: NOP_INS, data: '0};

  logic [1:0]      state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  beat_t           main_q, main_d;
  beat_t           skid_q, skid_d;
  logic            tag_q, tag_d;
  logic [PC_W-1:0] saved_q, saved_d;

  logic  accept_c;
  logic  drain_c;
  beat_t in_beat_c;

  assign accept_c  = bus.in_valid_i & in_ready_q;
  assign drain_c   = out_valid_q & bus.out_ready_i;
  // Beats in a branch shadow carry the branch pc for precise exceptions.
  assign in_beat_c = '{pc: (tag_q ? saved_q : bus.pc_i), ins: bus.ins_i, data: bus.data_i};

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= BUBBLE;
      skid_q      <= '0;
      tag_q       <= 1'b0;
      saved_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      tag_q       <= tag_d;
      saved_q     <= saved_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    tag_d   = tag_q;
    saved_d = saved_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = '0;
      tag_d   = 1'b0;
      saved_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            main_d  = in_beat_c;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept_c && drain_c) begin
            main_d = in_beat_c;
          end else if (accept_c) begin
            skid_d  = in_beat_c;
            state_d = ST_FULL;
          end else if (drain_c) begin
            main_d  = BUBBLE;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain_c) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = '0;
        end
      endcase
      // Branch set wins over slot end so a self-looping branch stays tagged.
      if (accept_c) begin
        if (bus.branch_tag_i) begin
          tag_d   = 1'b1;
          saved_d = bus.pc_i;
        end else if (tag_q && bus.branch_slot_end_i) begin
          tag_d = 1'b0;
        end
      end
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.pc_o        = main_q.pc;
  assign bus.ins_o       = main_q.ins;
  assign bus.data_o      = main_q.data;
  assign bus.occupancy_o = state_q;

`ifdef PIPE_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] drop_q, drop_d;
  logic [32:0] drop_sum_c;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      stall_q <= stall_d;
      drop_q  <= drop_d;
    end
  end

  // Saturating counters; flush never clears them.
  always_comb begin
    stall_d    = stall_q;
    drop_d     = drop_q;
    drop_sum_c = 33'(drop_q) + 33'(state_q);
    if (out_valid_q && !bus.out_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
    if (flush_i) begin
      drop_d = drop_sum_c[32] ? 32'hFFFF_FFFF : drop_sum_c[31:0];
    end
  end

  assign stall_cnt_o = stall_q;
  assign drop_cnt_o  = drop_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed and randomized bench for ex_mem_skid against a queue-based reference model.
module tb_ex_mem_skid;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_mem_skid_if #(.DATA_W(160), .PC_W(32), .INS_W(32)) bus ();

`ifdef PIPE_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] drop_cnt;
  logic [31:0] drop_before;
`endif

  ex_mem_skid #(.DATA_W(160), .PC_W(32), .INS_W(32), .NOP_INS(32'h00000013)) dut (
    .clk_i   (clk),
    .n_rst_i (rst_n),
    .flush_i (flush),
    .bus     (bus)
`ifdef PIPE_STATS_EN
    ,
    .stall_cnt_o (stall_cnt),
    .drop_cnt_o  (drop_cnt)
`endif
  );

  typedef struct {
    logic [31:0]  pc;
    logic [31:0]  ins;
    logic [159:0] data;
  } mbeat_t;

  // Reference model: an ordered list of held beats (at most two) plus the branch shadow.
  mbeat_t      q[$];
  logic [31:0] log_pc[$];
  logic        m_tag = 1'b0;
  logic [31:0] m_saved = '0;

  function automatic logic [159:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tag   = 1'b0;
    m_saved = '0;
  endtask

  task automatic model_edge();
    int     sz;
    mbeat_t b;
    if (!rst_n) return;
    if (flush) begin
      model_reset();
      return;
    end
    sz = q.size();
    if (sz > 0 && bus.out_ready_i) begin
      log_pc.push_back(q[0].pc);
      void'(q.pop_front());
    end
    if (bus.in_valid_i && sz < 2) begin
      b.pc   = m_tag ? m_saved : bus.pc_i;
      b.ins  = bus.ins_i;
      b.data = bus.data_i;
      q.push_back(b);
      if (bus.branch_tag_i) begin
        m_tag   = 1'b1;
        m_saved = bus.pc_i;
      end else if (bus.branch_slot_end_i) begin
        m_tag = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    logic         v;
    logic [31:0]  epc;
    logic [31:0]  eins;
    logic [159:0] edata;
    v     = (q.size() > 0);
    epc   = v ? q[0].pc : 32'h0;
    eins  = v ? q[0].ins : 32'h00000013;
    edata = v ? q[0].data : 160'h0;
    chk("out_valid", 160'(bus.out_valid_o), 160'(v));
    chk("in_ready", 160'(bus.in_ready_o), 160'(q.size() < 2));
    chk("occupancy", 160'(bus.occupancy_o), 160'(q.size()));
    chk("pc_o", 160'(bus.pc_o), 160'(epc));
    chk("ins_o", 160'(bus.ins_o), 160'(eins));
    chk("data_o", bus.data_o, edata);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(logic v, logic [31:0] pc, logic tag, logic send, logic rdy);
    bus.in_valid_i        = v;
    bus.pc_i              = pc;
    bus.ins_i             = $urandom;
    bus.data_i            = rnd_data();
    bus.branch_tag_i      = tag;
    bus.branch_slot_end_i = send;
    bus.out_ready_i       = rdy;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // Streaming with the sink always ready
    log_pc.delete();
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b1); step();
    chk("stream_occ", 160'(bus.occupancy_o), 160'd1);
    drive(1'b1, 32'h108, 1'b0, 1'b0, 1'b1); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); step(); step();
    chk("stream_cnt", 160'(log_pc.size()), 160'd3);
    chk("stream_0", 160'(log_pc[0]), 160'h100);
    chk("stream_1", 160'(log_pc[1]), 160'h104);
    chk("stream_2", 160'(log_pc[2]), 160'h108);

    // Backpressure fills both entries and holds off the third beat
    log_pc.delete();
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h204, 1'b0, 1'b0, 1'b0); step();
    chk("full_occ", 160'(bus.occupancy_o), 160'd2);
    chk("full_rdy", 160'(bus.in_ready_o), 160'd0);
    drive(1'b1, 32'h208, 1'b0, 1'b0, 1'b0); step(); step();
    bus.out_ready_i = 1'b1; step(); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); step(); step();
    chk("bp_cnt", 160'(log_pc.size()), 160'd3);
    chk("bp_0", 160'(log_pc[0]), 160'h200);
    chk("bp_1", 160'(log_pc[1]), 160'h204);
    chk("bp_2", 160'(log_pc[2]), 160'h208);

    // Branch shadow attribution
    log_pc.delete();
    drive(1'b1, 32'h300, 1'b1, 1'b0, 1'b1); step();
    drive(1'b1, 32'h304, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 32'h340, 1'b0, 1'b1, 1'b1); step();
    drive(1'b1, 32'h344, 1'b0, 1'b0, 1'b1); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); step(); step();
    chk("br_cnt", 160'(log_pc.size()), 160'd4);
    chk("br_0", 160'(log_pc[0]), 160'h300);
    chk("br_1", 160'(log_pc[1]), 160'h300);
    chk("br_2", 160'(log_pc[2]), 160'h300);
    chk("br_3", 160'(log_pc[3]), 160'h344);

    // Flush from FULL drops held beats and the offered beat
    log_pc.delete();
    drive(1'b1, 32'h3f0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h3f4, 1'b0, 1'b0, 1'b0); step();
`ifdef PIPE_STATS_EN
    drop_before = drop_cnt;
`endif
    drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    flush = 1'b1; step();
    flush = 1'b0;
    chk("flush_valid", 160'(bus.out_valid_o), 160'd0);
    chk("flush_occ", 160'(bus.occupancy_o), 160'd0);
    chk("flush_rdy", 160'(bus.in_ready_o), 160'd1);
`ifdef PIPE_STATS_EN
    chk("drop_cnt", 160'(drop_cnt), 160'(drop_before + 32'd2));
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); step(); step();
    chk("flush_none_out", 160'(log_pc.size()), 160'd0);

    // Async reset mid-transfer clears entries and the branch tracker
    log_pc.delete();
    drive(1'b1, 32'h600, 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, 32'h604, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h608, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    model_edge();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("arst_valid", 160'(bus.out_valid_o), 160'd0);
    chk("arst_ins", 160'(bus.ins_o), 160'h13);
    @(negedge clk);
    rst_n = 1'b1;
    log_pc.delete();
    drive(1'b1, 32'h700, 1'b0, 1'b0, 1'b1); step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); step(); step();
    chk("arst_cnt", 160'(log_pc.size()), 160'd1);
    chk("arst_pc", 160'(log_pc[0]), 160'h700);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
Parametrised successor of the EX/MEM pipeline register. It carries a generic payload plus pc/ins from execute to LSU using a valid/ready handshake instead of a stall vector. A 2-entry skid buffer sustains 1 beat/cycle with a registered in_ready_o. Branch-slot PC attribution is kept: instructions in a branch shadow report the branch PC, which keeps the exception PC precise.

Parameters:
DATA_W, 160, payload width (rd/uop/mem/csr/exception fields packed by the instantiating level)
PC_W, 32, width of pc and saved branch pc
INS_W, 32, instruction width
NOP_INS, 32'h00000013, instruction value driven when no beat is valid

Ports:
clk_i  in  1  clock, rising edge
n_rst_i  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous pipeline flush
in_valid_i  in  1  execute beat valid
in_ready_o  out  1  stage can accept (registered)
pc_i  in  PC_W  pc of incoming beat
ins_i  in  INS_W  instruction of incoming beat
data_i  in  DATA_W  payload of incoming beat
branch_tag_i  in  1  incoming beat is a branch
branch_slot_end_i  in  1  incoming beat is the branch target (shadow ends)
out_valid_o  out  1  beat available to LSU
out_ready_i  in  1  LSU accepts
pc_o  out  PC_W  attributed pc of output beat
ins_o  out  INS_W  instruction of output beat
data_o  out  DATA_W  payload of output beat
occupancy_o  out  2  entries held (0..2)

Behaviour:
- Reset (n_rst_i low, async): out_valid_o=0, in_ready_o=1, occupancy_o=0, pc_o=0, ins_o=NOP_INS, data_o=0, skid entry cleared, branch tracker cleared (tag=0, saved pc=0).
- accept = in_valid_i & in_ready_o; drain = out_valid_o & out_ready_i.
- States by occupancy: EMPTY(0), ONE(main valid), FULL(main+skid valid).
  - EMPTY: accept -> beat into main, ONE.
  - ONE: accept&drain -> new beat into main, ONE. accept only -> beat into skid, FULL. drain only -> EMPTY.
  - FULL: in_ready_o=0. drain -> skid moves into main, ONE. Otherwise hold.
- in_ready_o is registered: it equals !(next state==FULL). No combinational path from out_ready_i to in_ready_o.
- Latency 1 cycle from accept into EMPTY to out_valid_o. Sustained throughput 1 beat/cycle with out_ready_i held high.
- Beat order is preserved. The skid entry is never output before main.
- Whenever out_valid_o=0: pc_o=0, ins_o=NOP_INS, data_o=0 (bubble, no write side effects).
- Branch tracker updates only on accept:
  - branch_tag_i=1 -> tag<=1, saved<=pc_i.
  - else tag & branch_slot_end_i -> tag<=0.
  - Stored pc = old tag ? saved : pc_i.
  - tag and slot_end together: set wins (self-loop branch).
- flush_i (sync) has priority over accept and drain. It clears both entries and the tracker, and outputs the bubble values next cycle. in_ready_o=1 next cycle. A beat offered in the flush cycle is dropped.
- in_valid_i without accept: no state change, and the tracker is untouched.
- Async reset asserted mid-transfer discards all held beats immediately.

Optional Feature:
PIPE_STATS_EN: defined -> adds port stall_cnt_o (out, 32) and drop_cnt_o (out, 32).
- stall_cnt_o increments every cycle with out_valid_o & !out_ready_i.
- drop_cnt_o adds the number of valid entries discarded by flush_i.
- Both saturate at 32'hFFFFFFFF and reset to 0 on n_rst_i only (flush does not clear them).
Undefined -> ports and counters are absent, with no logic overhead.

Test Plan:
- Reset then idle -> out_valid_o=0, ins_o=32'h00000013, pc_o=0, in_ready_o=1, occupancy_o=0.
- Stream pc 0x100,0x104,0x108 with out_ready_i=1 -> outputs appear one cycle later, in order, one per cycle; occupancy_o stays 1.
- out_ready_i=0 while sending 0x200,0x204 -> occupancy_o=2, in_ready_o=0 from next cycle, 0x208 held off. Release -> 0x200,0x204,0x208 emitted in order, none lost.
- Branch at pc 0x300 (tag=1), then 0x304, 0x340 (slot_end=1), 0x344 -> pc_o sequence 0x300,0x300,0x300,0x344.
- FULL state plus flush_i with in_valid_i=1 (pc 0x400) -> next cycle out_valid_o=0, occupancy_o=0, 0x400 never output; with PIPE_STATS_EN, drop_cnt_o +=2.
- Assert n_rst_i low asynchronously mid-stream -> outputs go to reset values before the next clock edge, and the tracker is cleared (next beat reports its own pc).
